// File: rtl/button_conditioner_pkg.sv
// Shared types for the button conditioner: Up/Down FSM states, the latched
// direction, and the electrical meaning of a button level (active-low).
package button_conditioner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FIRST  = 3'd1,
    ST_DELAY  = 3'd2,
    ST_REPEAT = 3'd3,
    ST_LOCK   = 3'd4
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic PRESSED  = 1'b0;
  localparam logic RELEASED = 1'b1;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: 2-flop synchroniser followed by a stability counter.
// The debounced level flips only after the synchronised sample has differed
// from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample restarts
// the count.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic [CW-1:0] cnt_r;
  logic          level_r;

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sync1_r <= RELEASED;
      sync2_r <= RELEASED;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Stability counter; the last differing sample of a full run flips the level.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cnt_r   <= CNT_ZERO;
      level_r <= RELEASED;
    end else if (sync2_r == level_r) begin
      cnt_r <= CNT_ZERO;
    end else if (cnt_r >= CNT_LAST) begin
      level_r <= sync2_r;
      cnt_r   <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign level = level_r;

endmodule

// File: rtl/button_conditioner.sv
// Button conditioner: three debounced channels; Up/Down feed one shared
// FSM producing single-cycle pulses with delayed auto-repeat, Sign is passed
// through as a debounced level.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Btn_Up,
  input  logic Btn_Down,
  input  logic Btn_Sign,
  output logic Up,
  output logic Down,
  output logic Sign
);

  localparam int DW = $clog2(REPEAT_DELAY + 1);
  localparam int RW = $clog2(REPEAT_RATE + 1);
  localparam logic [DW-1:0] DLY_ZERO = DW'(0);
  localparam logic [DW-1:0] DLY_ONE  = DW'(1);
  localparam logic [DW-1:0] DLY_LAST = DW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_ZERO = RW'(0);
  localparam logic [RW-1:0] RPT_ONE  = RW'(1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_RATE - 1);

  logic          up_level_s;
  logic          down_level_s;
  logic          sign_level_s;
  logic          up_p_s;
  logic          down_p_s;
  logic          held_s;
  logic          opp_s;
  state_t        state_r;
  dir_t          dir_r;
  logic [DW-1:0] delay_cnt_r;
  logic [RW-1:0] rate_cnt_r;
  logic          up_r;
  logic          down_r;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .Clock(Clock), .Reset(Reset), .raw(Btn_Up), .level(up_level_s)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .Clock(Clock), .Reset(Reset), .raw(Btn_Down), .level(down_level_s)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sign (
    .Clock(Clock), .Reset(Reset), .raw(Btn_Sign), .level(sign_level_s)
  );

  assign up_p_s   = (up_level_s == PRESSED);
  assign down_p_s = (down_level_s == PRESSED);

  // Resolve the latched button and its opposite from the stored direction.
  always_comb begin
    held_s = 1'b0;
    opp_s  = 1'b0;
    if (dir_r == DIR_UP) begin
      held_s = up_p_s;
      opp_s  = down_p_s;
    end else begin
      held_s = down_p_s;
      opp_s  = up_p_s;
    end
  end

  // Up/Down FSM; pulses are registered and raised on entry to the pulse cycle.
  // A conflicting press wins over a release, and a release wins over a due
  // repeat pulse, so no pulse escapes once the latched button is let go.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_r     <= ST_IDLE;
      dir_r       <= DIR_UP;
      delay_cnt_r <= DLY_ZERO;
      rate_cnt_r  <= RPT_ZERO;
      up_r        <= 1'b0;
      down_r      <= 1'b0;
    end else begin
      up_r   <= 1'b0;
      down_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (up_p_s && down_p_s) begin
            state_r <= ST_LOCK;
          end else if (up_p_s) begin
            dir_r   <= DIR_UP;
            up_r    <= 1'b1;
            state_r <= ST_FIRST;
          end else if (down_p_s) begin
            dir_r   <= DIR_DOWN;
            down_r  <= 1'b1;
            state_r <= ST_FIRST;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FIRST: begin
          delay_cnt_r <= DLY_ZERO;
          state_r     <= ST_DELAY;
        end
        ST_DELAY: begin
          if (opp_s) begin
            state_r <= ST_LOCK;
          end else if (!held_s) begin
            state_r <= ST_IDLE;
          end else if (delay_cnt_r >= DLY_LAST) begin
            up_r       <= (dir_r == DIR_UP);
            down_r     <= (dir_r == DIR_DOWN);
            rate_cnt_r <= RPT_ZERO;
            state_r    <= ST_REPEAT;
          end else begin
            delay_cnt_r <= delay_cnt_r + DLY_ONE;
          end
        end
        ST_REPEAT: begin
          if (opp_s) begin
            state_r <= ST_LOCK;
          end else if (!held_s) begin
            state_r <= ST_IDLE;
          end else if (rate_cnt_r >= RPT_LAST) begin
            up_r       <= (dir_r == DIR_UP);
            down_r     <= (dir_r == DIR_DOWN);
            rate_cnt_r <= RPT_ZERO;
          end else begin
            rate_cnt_r <= rate_cnt_r + RPT_ONE;
          end
        end
        ST_LOCK: begin
          if (!up_p_s && !down_p_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_LOCK;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign Up   = up_r;
  assign Down = down_r;
  assign Sign = sign_level_s;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_RATE=5. Cycle n of a scenario is the interval after
// the n-th rising edge following the step that applied the first stimulus;
// raw inputs change 1 time unit after an edge and outputs are checked there.
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  logic Clock;
  logic Reset;
  logic Btn_Up;
  logic Btn_Down;
  logic Btn_Sign;
  logic Up;
  logic Down;
  logic Sign;

  int total = 0;
  int bad   = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_RATE(5)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Btn_Up(Btn_Up),
    .Btn_Down(Btn_Down),
    .Btn_Sign(Btn_Sign),
    .Up(Up),
    .Down(Down),
    .Sign(Sign)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_bit(input string tag, input int n, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input int n, input state_t exp);
    total++;
    assert (dut.state_r === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, n, dut.state_r, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int n, input logic up_e, input logic down_e, input logic sign_e);
    check_bit({tag, "_up"}, n, Up, up_e);
    check_bit({tag, "_down"}, n, Down, down_e);
    check_bit({tag, "_sign"}, n, Sign, sign_e);
    check_bit({tag, "_excl"}, n, Up & Down, 1'b0);
  endtask

  initial begin
    Reset    = 1'b0;
    Btn_Up   = 1'b1;
    Btn_Down = 1'b1;
    Btn_Sign = 1'b1;

    // Reset values
    repeat (3) tick();
    check_outs("reset", 0, 1'b0, 1'b0, 1'b1);
    check_state("reset_state", 0, ST_IDLE);
    Reset = 1'b1;
    repeat (10) tick();

    // Short press of 3 cycles never reaches the debounced level
    Btn_Up = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      tick();
      check_outs("short", n, 1'b0, 1'b0, 1'b1);
      if (n == 3) Btn_Up = 1'b1;
    end
    repeat (5) tick();

    // Held Up: first pulse at 7, repeat at 18 then every 5 cycles. The
    // release is timed so the debounced release reaches the FSM at edge 43,
    // where it must suppress the repeat that would otherwise fall there.
    Btn_Up = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      check_outs("hold_up", n,
                 (n == 7 || n == 18 || n == 23 || n == 28 || n == 33 || n == 38),
                 1'b0, 1'b1);
      if (n == 36) Btn_Up = 1'b1;
    end
    check_state("hold_up_idle", 60, ST_IDLE);
    repeat (5) tick();

    // Bouncing Down for 10 cycles, then held: one pulse 7 cycles after the
    // bounce stops; released before the delayed repeat can fire
    Btn_Down = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      check_outs("bounce_dn", n, 1'b0, (n == 17), 1'b1);
      if (n < 10) Btn_Down = logic'(n % 2);
      else if (n >= 20) Btn_Down = 1'b1;
      else Btn_Down = 1'b0;
    end
    repeat (5) tick();

    // Sign held 20 cycles: level falls at 6, rises 6 after release
    Btn_Sign = 1'b0;
    for (int n = 1; n <= 35; n++) begin
      tick();
      check_outs("sign", n, 1'b0, 1'b0, (n < 6 || n >= 26));
      if (n == 20) Btn_Sign = 1'b1;
    end
    repeat (5) tick();

    // Up held into REPEAT, Down pressed: lock until both are released
    Btn_Up = 1'b0;
    for (int n = 1; n <= 70; n++) begin
      tick();
      check_outs("lock", n, (n == 7 || n == 18 || n == 23), 1'b0, 1'b1);
      if (n == 45) check_state("lock_held", n, ST_LOCK);
      if (n == 56) check_state("lock_one_left", n, ST_LOCK);
      if (n == 62) check_state("lock_exit", n, ST_IDLE);
      if (n == 20) Btn_Down = 1'b0;
      if (n == 40) Btn_Up = 1'b1;
      if (n == 50) Btn_Down = 1'b1;
    end
    repeat (5) tick();

    // Fresh Down press after the lock yields a Down pulse
    Btn_Down = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      tick();
      check_outs("after_lock_dn", n, 1'b0, (n == 7), 1'b1);
      if (n == 10) Btn_Down = 1'b1;
    end
    repeat (5) tick();

    // Reset during REPEAT cancels everything; held Up re-pulses 7 cycles later
    Btn_Up = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      tick();
      check_outs("rst_rpt", n, (n == 7 || n == 18 || n == 28), 1'b0, 1'b1);
      if (n == 21) begin
        check_state("rst_rpt_idle", n, ST_IDLE);
        Reset = 1'b1;
      end
      if (n == 20) Reset = 1'b0;
      if (n == 30) Btn_Up = 1'b1;
    end
    check_state("final_idle", 50, ST_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
